// File: rtl/reglk_pkg.sv
// Shared types and defaults for the register-lock controller.
package reglk_pkg;

  typedef enum logic [1:0] {
    StLocked,
    StWaitKey,
    StUnlocked,
    StLockout
  } unlock_state_e;

  localparam int unsigned NumWordsDefault  = 6;
  localparam logic [31:0] UnlockKeyDefault = 32'hA5C3_5A3C;

  localparam logic OpSet   = 1'b0;
  localparam logic OpClear = 1'b1;

endpackage

// File: rtl/reglk_unlock_fsm.sv
// Debug unlock state machine: key entry with timeout, failure counting and permanent lockout.
module reglk_unlock_fsm
  import reglk_pkg::*;
#(
  parameter logic [31:0] UNLOCK_KEY  = UnlockKeyDefault,
  parameter int unsigned KEY_TIMEOUT = 16,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          unlock_req_i,
  input  logic          key_valid_i,
  input  logic [31:0]   key_i,
  input  logic          relock_i,
  output unlock_state_e state_o,
  output logic          unlocked_o,
  output logic          lockout_o
);

  localparam int unsigned CntW  = $clog2(KEY_TIMEOUT + 1);
  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);

  unlock_state_e    r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [FailW-1:0] r_fails, w_fails_d;
  logic             w_fail;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StLocked;
      r_cnt   <= '0;
      r_fails <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_fails <= w_fails_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_fails_d = r_fails;
    w_fail    = 1'b0;
    unique case (r_state)
      StLocked: begin
        if (unlock_req_i) begin
          w_state_d = StWaitKey;
          w_cnt_d   = CntW'(KEY_TIMEOUT);
        end
      end
      StWaitKey: begin
        // A presented key takes priority over an expiring timeout.
        if (key_valid_i) begin
          if (key_i == UNLOCK_KEY) begin
            w_state_d = StUnlocked;
            w_fails_d = '0;
          end else begin
            w_fail = 1'b1;
          end
        end else if (r_cnt == '0) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StUnlocked: begin
        if (relock_i) w_state_d = StLocked;
      end
      StLockout: ;
    endcase

    if (w_fail) begin
      w_cnt_d = '0;
      if (r_fails >= FailW'(MAX_TRIES - 1)) begin
        w_fails_d = FailW'(MAX_TRIES);
        w_state_d = StLockout;
      end else begin
        w_fails_d = r_fails + FailW'(1);
        w_state_d = StLocked;
      end
    end
  end

  assign state_o    = r_state;
  assign unlocked_o = (r_state == StUnlocked);
  assign lockout_o  = (r_state == StLockout);

endmodule

// File: rtl/reglk_ctrl.sv
// Lock-bit array with a single-outstanding set/clear request path, gated by the debug unlock FSM.
module reglk_ctrl
  import reglk_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = NumWordsDefault,
  parameter logic [31:0] UNLOCK_KEY  = UnlockKeyDefault,
  parameter int unsigned KEY_TIMEOUT = 16,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_idx_i,
  input  logic                      req_op_i,
  input  logic [31:0]               req_wdata_i,
  output logic                      req_ack_o,
  output logic                      req_err_o,
  input  logic                      dbg_unlock_req_i,
  input  logic                      dbg_key_valid_i,
  input  logic [31:0]               dbg_key_i,
  input  logic                      dbg_relock_i,
  output logic                      dbg_unlocked_o,
  output logic                      dbg_lockout_o,
  output logic [NUM_WORDS-1:0][31:0] reglk_o
);

  logic                       r_pend, r_ack, r_err, r_op;
  logic [2:0]                 r_idx;
  logic [31:0]                r_wdata;
  logic [NUM_WORDS-1:0][31:0] r_reglk, w_reglk_d;
  logic                       w_accept, w_idx_ok, w_ok;
  unlock_state_e              w_state;

  reglk_unlock_fsm #(
    .UNLOCK_KEY  (UNLOCK_KEY),
    .KEY_TIMEOUT (KEY_TIMEOUT),
    .MAX_TRIES   (MAX_TRIES)
  ) u_unlock_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .unlock_req_i (dbg_unlock_req_i),
    .key_valid_i  (dbg_key_valid_i),
    .key_i        (dbg_key_i),
    .relock_i     (dbg_relock_i),
    .state_o      (w_state),
    .unlocked_o   (dbg_unlocked_o),
    .lockout_o    (dbg_lockout_o)
  );

  // Busy from accept until the ack/err cycle has passed.
  assign req_ready_o = !(r_pend || r_ack || r_err);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_idx_ok    = (32'(r_idx) < NUM_WORDS);
  // Uses the FSM state before any transition on the commit edge.
  assign w_ok        = w_idx_ok && ((r_op == OpSet) || (w_state == StUnlocked));

  always_comb begin
    w_reglk_d = r_reglk;
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (r_idx == w[2:0]) begin
        w_reglk_d[w] = (r_op == OpSet) ? (r_reglk[w] | r_wdata) : (r_reglk[w] & ~r_wdata);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_reglk <= '0;
    end else begin
      r_pend <= w_accept;
      r_ack  <= r_pend && w_ok;
      r_err  <= r_pend && !w_ok;
      if (w_accept) begin
        r_idx   <= req_idx_i;
        r_op    <= req_op_i;
        r_wdata <= req_wdata_i;
      end
      if (r_pend && w_ok) r_reglk <= w_reglk_d;
    end
  end

  assign req_ack_o = r_ack;
  assign req_err_o = r_err;
  assign reglk_o   = r_reglk;

endmodule

// File: doc/reglk_ctrl.md
REGLK_CTRL -- requirements
Module: reglk_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 6, number of 32-bit lock words.
REQ-002 SHALL have parameter UNLOCK_KEY, default 32'hA5C3_5A3C, debug unlock key.
REQ-003 SHALL have parameter KEY_TIMEOUT, default 16, cycles allowed for key entry.
REQ-004 SHALL have parameter MAX_TRIES, default 3, failed key attempts before lockout.
REQ-005 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  synchronous, active-high global reset; the only reset input.
REQ-007 SHALL have port req_valid_i  in  1  lock-write request valid.
REQ-008 SHALL have port req_ready_o  out  1  request accept.
REQ-009 SHALL have port req_idx_i  in  3  target lock word index.
REQ-010 SHALL have port req_op_i  in  1  0 = set bits, 1 = clear bits.
REQ-011 SHALL have port req_wdata_i  in  32  bit mask.
REQ-012 SHALL have port req_ack_o  out  1  one-cycle commit pulse.
REQ-013 SHALL have port req_err_o  out  1  one-cycle reject pulse, coincident with ack slot.
REQ-014 SHALL have port dbg_unlock_req_i  in  1  start debug unlock.
REQ-015 SHALL have port dbg_key_valid_i  in  1  key presented.
REQ-016 SHALL have port dbg_key_i  in  32  key value.
REQ-017 SHALL have port dbg_relock_i  in  1  leave unlocked state.
REQ-018 SHALL have port dbg_unlocked_o  out  1  high in UNLOCKED only.
REQ-019 SHALL have port dbg_lockout_o  out  1  high in LOCKOUT only.
REQ-020 SHALL have port reglk_o  out  NUM_WORDS x 32  current lock bits.

Function
REQ-021 SHALL accept a request on valid && ready; ready SHALL drop the cycle after accept and return high the cycle after ack/err (one outstanding).
REQ-022 SHALL commit an accepted request one cycle after accept, pulsing exactly one of req_ack_o or req_err_o that cycle.
REQ-023 Set: reglk[idx] <= reglk[idx] | wdata, allowed in any FSM state; reglk_o updates at the commit edge.
REQ-024 Clear: reglk[idx] <= reglk[idx] & ~wdata only when FSM is UNLOCKED at commit; otherwise err, no change.
REQ-025 idx >= NUM_WORDS SHALL produce err with no change.
REQ-026 Unlock FSM states: LOCKED, WAIT_KEY, UNLOCKED, LOCKOUT.
REQ-027 LOCKED -> WAIT_KEY on dbg_unlock_req_i; timeout counter loads KEY_TIMEOUT.
REQ-028 WAIT_KEY: key_valid && key == UNLOCK_KEY -> UNLOCKED, fail count cleared.
REQ-029 WAIT_KEY: wrong key, or counter reaching 0 with no key, -> LOCKED, fail count +1 (saturating).
REQ-030 Fail count reaching MAX_TRIES SHALL go to LOCKOUT; LOCKOUT exits only on rst_i.
REQ-031 UNLOCKED -> LOCKED on dbg_relock_i; lock bits are NOT cleared by any unlock/relock transition.
REQ-032 Clear committed in the same cycle as relock SHALL use the pre-transition state (allowed).
REQ-033 Key valid and timeout expiry in the same cycle: key evaluation wins.

Reset
REQ-034 rst_i SHALL set all reglk words to 0, FSM to LOCKED, fail count 0, counter 0, req_ready_o 1, ack/err 0, drop any in-flight request.
REQ-035 No other input (debug, request, per-block reset) SHALL clear lock bits wholesale.

Structure
REQ-036 State enum, NUM_WORDS and UNLOCK_KEY default SHALL live in shared package reglk_pkg.
REQ-037 The unlock FSM SHALL be sub-module reglk_unlock_fsm; the lock array and request path stay in the top.

Verification
REQ-038 Reset, set idx 2 mask 32'h0000_00FF -> ack next cycle, reglk_o[2] = 32'h0000_00FF.
REQ-039 Clear idx 2 mask 32'hFF while LOCKED -> err, reglk_o[2] unchanged.
REQ-040 Unlock req, key 32'hA5C3_5A3C -> dbg_unlocked_o=1; clear idx 2 mask 32'h0F -> reglk_o[2] = 32'hF0; relock -> value retained.
REQ-041 Three wrong keys (or three 16-cycle timeouts) -> dbg_lockout_o=1; correct key then ignored until rst_i.
REQ-042 Request idx 6 -> err; rst_i asserted mid-request -> no ack, all words 0, ready=1 next cycle.
